batch_stream_host: RTL and testbench
====================================

// Module: batch_stream_host
// PURPOSE
// Host-side counterpart of the batch controller: plays a batch of samples from a source RAM
// into the accelerator's src stream and collects the results from its dst stream into a result RAM.
// Per sample it sends ss+1 words (src_last on the final word), then accepts ds+1 result words.
// It repeats this ns+1 times.
// Sits between the DMA buffers and the accelerator; used as the test/host driver for the MNIST layers.
// PARAMETERS
// DW    32  stream/RAM data width
// AW    16  source and result RAM address width
// NSW    8  sample-count width
// PORTS
// clk        in   1    clock
// rst_n      in   1    asynchronous active-low reset
// start      in   1    pulse: begin batch (ignored while busy)
// ss         in   12   source words per sample minus 1
// ds         in   12   result words per sample minus 1
// ns         in   NSW  samples per batch minus 1
// out_stall  in   1    force dst_ready low (host backpressure)
// busy       out  1    batch in progress
// done       out  1    one-cycle pulse after last result word written
// proto_err  out  1    sticky: dst_valid seen outside RECV; cleared by start
// rd_en      out  1    source RAM read strobe
// rd_a       out  AW   source RAM address
// rd_d       in   DW   source RAM data, valid 1 cycle after rd_en
// src_valid  out  1    stream word valid
// src_last   out  1    final word of sample
// src_data   out  DW   stream word
// src_ready  in   1    accelerator accepts
// dst_valid  in   1    result word valid
// dst_data   in   DW   result word
// dst_ready  out  1    host accepts
// wr_en      out  1    result RAM write strobe
// wr_a       out  AW   result RAM address
// wr_d       out  DW   result RAM data
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; all counters 0. Reset mid-batch aborts immediately; no resume.
// - FSM: IDLE -start-> SEND. SEND -(last word accepted: src_valid&src_ready&src_last)-> RECV.
//   RECV -(word ds accepted, sample<ns)-> SEND. RECV -(word ds accepted, sample==ns)-> DONE.
//   DONE -> IDLE (1 cycle, done=1). busy=1 in SEND/RECV/DONE.
// - start in IDLE: rd_a<=0, wr_a<=0, sample<=0, proto_err<=0.
// - SEND prefetch: rd_en issues while the 2-entry skid buffer has room (counting in-flight reads)
//   and fewer than ss+1 reads have been issued for this sample. rd_a increments per read,
//   continuously across samples. Sample k word i is at k*(ss+1)+i.
// - src stream: valid/ready, transfer when src_valid&src_ready. src_data/src_valid/src_last are
//   held stable while src_valid&~src_ready. src_last is high only on word ss.
//   With ss=0 every word is last.
// - Throughput: with src_ready held high, 1 word/cycle after 2-cycle initial latency
//   (start->first src_valid).
// - No reads are issued beyond word ss of the current sample. The buffer is empty on leaving SEND.
// - RECV: dst_ready = ~out_stall. On dst_valid&dst_ready: wr_en=1 the same cycle (combinational),
//   wr_a=current result addr, wr_d=dst_data; wr_a++ and word counter++.
//   wr_a is continuous across samples.
// - dst_ready=0 outside RECV. dst_valid=1 outside RECV sets proto_err; the data is dropped.
// - Counters are 12-bit (words) and NSW-bit (samples), compared for equality with ss/ds/ns,
//   never wrapping within a sample. RAM addresses are AW bits and wrap modulo 2^AW silently.
// - ss/ds/ns are sampled at start into internal registers; changes while busy have no effect.
// - start while busy: ignored. start coincident with DONE: ignored (IDLE must be seen first).
// STRUCTURE
// - Package batch_host_pkg: typedef enum logic[2:0] {IDLE,SEND,RECV,DONE} host_state_t;
//   localparam SKID_DEPTH=2.
// - Sub-module stream_skid_buf (2-entry FIFO with valid/ready out, count output for prefetch
//   credit). Top holds the FSM, counters and write path.
// TESTING
// 1 ss=3,ds=1,ns=0, src_ready=1, RAM[i]=i: src words 0,1,2,3 with last on 3; two dst words
//   written to wr_a 0,1; done 1 cycle after second write.
// 2 ss=3, src_ready toggling 1010: data/last stable while stalled; exactly 4 transfers;
//   rd_a never exceeds 3.
// 3 ss=0,ds=0,ns=2: three samples; every src word last; src data 0,1,2; writes to wr_a 0,1,2.
// 4 out_stall high 5 cycles during RECV: dst_ready=0, no wr_en; after release remaining words
//   written in order.
// 5 dst_valid pulsed in IDLE -> proto_err=1; next start clears it; no wr_en.
// 6 rst_n low mid-SEND (word 2 of 4): all outputs 0 asynchronously; new start restarts at rd_a=0.

Source files
------------

// File: rtl/batch_host_pkg.sv
// Shared types and constants for the batch stream host.
package batch_host_pkg;

  typedef enum logic [2:0] {IDLE, SEND, RECV, DONE} host_state_t;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned CW         = 12;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry fall-through FIFO between the source RAM read port and the src stream.
// count reports stored entries so the producer can budget outstanding reads.
module stream_skid_buf
  import batch_host_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [SKID_DEPTH];
  logic          head_q;
  logic [1:0]    cnt_q;
  logic          push, pop, tail;

  always_comb begin
    pop       = (cnt_q != 2'd0) && out_ready;
    // An arriving word bypasses storage when the buffer is empty and the sink takes it.
    push      = in_valid && !((cnt_q == 2'd0) && out_ready);
    tail      = head_q ^ cnt_q[0];
    out_valid = (cnt_q != 2'd0) || in_valid;
    out_data  = (cnt_q != 2'd0) ? mem_q[head_q] : (in_valid ? in_data : '0);
    count     = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) mem_q[tail] <= in_data;
      if (pop)  head_q <= ~head_q;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/batch_stream_host.sv
// Host driver: streams each sample from the source RAM to the accelerator, then
// stores its result words into the result RAM, for ns+1 samples per batch.
module batch_stream_host
  import batch_host_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 16,
  parameter int unsigned NSW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [CW-1:0]  ss,
  input  logic [CW-1:0]  ds,
  input  logic [NSW-1:0] ns,
  input  logic           out_stall,
  output logic           busy,
  output logic           done,
  output logic           proto_err,
  output logic           rd_en,
  output logic [AW-1:0]  rd_a,
  input  logic [DW-1:0]  rd_d,
  output logic           src_valid,
  output logic           src_last,
  output logic [DW-1:0]  src_data,
  input  logic           src_ready,
  input  logic           dst_valid,
  input  logic [DW-1:0]  dst_data,
  output logic           dst_ready,
  output logic           wr_en,
  output logic [AW-1:0]  wr_a,
  output logic [DW-1:0]  wr_d
);

  host_state_t    state_q, state_d;
  logic [CW-1:0]  ss_q, ds_q, rd_cnt_q, tx_cnt_q, rx_cnt_q;
  logic [NSW-1:0] ns_q, sample_q;
  logic [AW-1:0]  rd_a_q, wr_a_q;
  logic           rd_done_q, rd_pend_q, proto_err_q;
  logic           fifo_valid, fifo_ready, src_fire, dst_fire, start_ok, sample_end;
  logic [DW-1:0]  fifo_data;
  logic [1:0]     fifo_cnt;
  logic [2:0]     credit_used;

  stream_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_pend_q),
    .in_data  (rd_d),
    .out_valid(fifo_valid),
    .out_ready(fifo_ready),
    .out_data (fifo_data),
    .count    (fifo_cnt)
  );

  always_comb begin
    start_ok    = (state_q == IDLE) && start;
    // Reads still in flight count against buffer space so a stall can never overflow it.
    credit_used = {1'b0, fifo_cnt} + {2'b00, rd_pend_q};
    rd_en       = (state_q == SEND) && !rd_done_q && (credit_used < 3'(SKID_DEPTH));
    rd_a        = rd_a_q;
    src_valid   = (state_q == SEND) && fifo_valid;
    src_data    = src_valid ? fifo_data : '0;
    src_last    = src_valid && (tx_cnt_q == ss_q);
    fifo_ready  = (state_q == SEND) && src_ready;
    src_fire    = src_valid && src_ready;
    dst_ready   = (state_q == RECV) && !out_stall;
    dst_fire    = dst_valid && dst_ready;
    sample_end  = dst_fire && (rx_cnt_q == ds_q);
    wr_en       = dst_fire;
    wr_a        = wr_a_q;
    wr_d        = dst_fire ? dst_data : '0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    proto_err   = proto_err_q;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (src_fire && src_last) state_d = RECV;
      RECV:    if (sample_end) state_d = (sample_q == ns_q) ? DONE : SEND;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ss_q        <= '0;
      ds_q        <= '0;
      ns_q        <= '0;
      sample_q    <= '0;
      rd_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      rd_a_q      <= '0;
      wr_a_q      <= '0;
      rd_done_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_en;
      if (start_ok) begin
        ss_q        <= ss;
        ds_q        <= ds;
        ns_q        <= ns;
        sample_q    <= '0;
        rd_cnt_q    <= '0;
        tx_cnt_q    <= '0;
        rx_cnt_q    <= '0;
        rd_a_q      <= '0;
        wr_a_q      <= '0;
        rd_done_q   <= 1'b0;
        proto_err_q <= 1'b0;
      end
      if (rd_en) begin
        rd_a_q <= rd_a_q + AW'(1);
        if (rd_cnt_q == ss_q) rd_done_q <= 1'b1;
        else                  rd_cnt_q  <= rd_cnt_q + CW'(1);
      end
      if (src_fire) tx_cnt_q <= src_last ? '0 : tx_cnt_q + CW'(1);
      if (dst_fire) begin
        wr_a_q <= wr_a_q + AW'(1);
        if (sample_end) begin
          rx_cnt_q  <= '0;
          sample_q  <= sample_q + NSW'(1);
          rd_cnt_q  <= '0;
          rd_done_q <= 1'b0;
        end else begin
          rx_cnt_q <= rx_cnt_q + CW'(1);
        end
      end
      // Results arriving outside the receive phase are dropped but remembered.
      if (dst_valid && (state_q != RECV)) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_batch_stream_host.sv
// Scoreboard bench for batch_stream_host: a source RAM model, an accelerator model and
// a negedge monitor that checks every stream transfer and RAM write against queues.
module tb_batch_stream_host;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 16;
  localparam int unsigned NSW = 8;

  logic           clk, rst_n, start, out_stall;
  logic [11:0]    ss, ds;
  logic [NSW-1:0] ns;
  logic           busy, done, proto_err, rd_en;
  logic [AW-1:0]  rd_a, wr_a;
  logic [DW-1:0]  rd_d, src_data, dst_data, wr_d;
  logic           src_valid, src_last, src_ready, dst_valid, dst_ready, wr_en;

  batch_stream_host #(.DW(DW), .AW(AW), .NSW(NSW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ss(ss), .ds(ds), .ns(ns),
    .out_stall(out_stall), .busy(busy), .done(done), .proto_err(proto_err),
    .rd_en(rd_en), .rd_a(rd_a), .rd_d(rd_d),
    .src_valid(src_valid), .src_last(src_last), .src_data(src_data), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
    .wr_en(wr_en), .wr_a(wr_a), .wr_d(wr_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_key;
  // Source RAM: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_d <= {16'h0, rd_a} ^ mem_key;

  logic [32:0] src_q[$];
  logic [47:0] wr_q[$];
  int ss_m, ds_m, ns_m, exp_rd_a, exp_wr_a, reads_issued, lasts_seen, src_xfers;
  int writes_seen, total_writes, total_src;
  bit mon_en, done_exp, prev_stall, batch_over;
  logic [32:0] prev_word, exp_word;
  logic [47:0] exp_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
  endtask

  task automatic setup_model(input int s, input int d, input int n, input logic [31:0] key);
    ss_m = s; ds_m = d; ns_m = n; mem_key = key;
    src_q.delete(); wr_q.delete();
    for (int k = 0; k <= n; k++)
      for (int i = 0; i <= s; i++)
        src_q.push_back({(i == s), 32'((k * (s + 1) + i) % 65536) ^ key});
    total_src = (n + 1) * (s + 1);
    total_writes = (n + 1) * (d + 1);
    exp_rd_a = 0; exp_wr_a = 0; reads_issued = 0; lasts_seen = 0; src_xfers = 0;
    writes_seen = 0; done_exp = 0; prev_stall = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("src_hold_valid", src_valid, 1);
        check("src_hold_word", {src_last, src_data}, prev_word);
      end
      if (rd_en) begin
        check("rd_addr", rd_a, 16'(exp_rd_a));
        check("rd_window", reads_issued < (lasts_seen + 1) * (ss_m + 1), 1);
        exp_rd_a++;
        reads_issued++;
      end
      if (src_valid && src_ready) begin
        src_xfers++;
        if (src_q.size() == 0) note_fail("src_extra_word", src_xfers, total_src);
        else begin
          exp_word = src_q.pop_front();
          check("src_word", {src_last, src_data}, exp_word);
          if (exp_word[32]) lasts_seen++;
        end
      end
      prev_stall = src_valid && !src_ready;
      prev_word = {src_last, src_data};
      if (out_stall) begin
        check("stall_dst_ready", dst_ready, 0);
        check("stall_no_wr", wr_en, 0);
      end
      if (wr_en) begin
        check("wr_handshake", dst_valid && dst_ready, 1);
        writes_seen++;
        if (wr_q.size() == 0) note_fail("wr_extra", writes_seen, total_writes);
        else begin
          exp_wr = wr_q.pop_front();
          check("wr_addr_data", {wr_a, wr_d}, exp_wr);
        end
      end
      check("done", done, done_exp);
      done_exp = wr_en && (writes_seen == total_writes);
    end
  end

  task automatic acc_run();
    int n;
    bit got;
    logic [31:0] d;
    for (int k = 0; k <= ns_m; k++) begin
      n = 0;
      while (lasts_seen <= k && n < 1000) begin @(posedge clk); #1; n++; end
      if (lasts_seen <= k) begin note_fail("acc_wait_last", lasts_seen, k + 1); return; end
      for (int i = 0; i <= ds_m; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        d = $urandom;
        dst_valid = 1'b1;
        dst_data = d;
        wr_q.push_back({16'(exp_wr_a), d});
        exp_wr_a++;
        n = 0; got = 0;
        while (!got && n < 300) begin
          @(negedge clk);
          if (dst_ready) got = 1;
          @(posedge clk); #1;
          n++;
        end
        dst_valid = 1'b0;
        if (!got) begin note_fail("acc_wait_ready", 0, 1); return; end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 300);
    if (busy) note_fail("wait_idle", n, 300);
  endtask

  task automatic stall_run();
    int n = 0;
    while (writes_seen == 0 && n < 1000) begin @(posedge clk); #1; n++; end
    if (writes_seen == 0) begin note_fail("stall_wait_write", 0, 1); return; end
    out_stall = 1'b1;
    repeat (5) @(posedge clk);
    #1 out_stall = 1'b0;
  endtask

  // rmode: 0 ready held high, 1 ready toggling 1010, 2 random ready
  task automatic run_batch(input int s, input int d, input int n, input logic [31:0] key,
                           input int rmode, input bit stall_en);
    setup_model(s, d, n, key);
    src_ready = (rmode != 2) ? 1'b1 : 1'($urandom_range(0, 1));
    mon_en = 1;
    @(posedge clk); #1;
    ss = 12'(s); ds = 12'(d); ns = NSW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ss = 12'($urandom); ds = 12'($urandom); ns = NSW'($urandom);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("proto_err_cleared", proto_err, 0);
    if (rmode == 0) check("first_valid_cycle1", src_valid, 0);
    @(negedge clk);
    if (rmode == 0) check("first_valid_cycle2", src_valid, 1);
    batch_over = 0;
    fork
      begin acc_run(); wait_idle(); batch_over = 1; end
      begin
        while (!batch_over) begin
          @(posedge clk); #1;
          if (rmode == 1) src_ready = ~src_ready;
          else if (rmode == 2) src_ready = 1'($urandom_range(0, 1));
        end
      end
      begin if (stall_en) stall_run(); end
    join
    @(negedge clk);
    check("src_drained", src_q.size(), 0);
    check("wr_drained", wr_q.size(), 0);
    check("reads_total", reads_issued, total_src);
    check("writes_total", writes_seen, total_writes);
    check("idle_busy", busy, 0);
    check("batch_proto_err", proto_err, 0);
  endtask

  initial begin
    int n;
    rst_n = 0; start = 0; ss = 0; ds = 0; ns = 0; out_stall = 0; src_ready = 0;
    dst_valid = 0; dst_data = 0; mem_key = 0; mon_en = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_outputs", {done, proto_err, rd_en, src_valid, src_last, dst_ready, wr_en}, 0);
    @(negedge clk); rst_n = 1;

    run_batch(3, 1, 0, 32'h0, 0, 0);
    run_batch(3, 0, 0, 32'h0, 1, 0);
    run_batch(0, 0, 2, 32'h0, 0, 0);
    run_batch(2, 7, 1, $urandom, 2, 1);

    // Result word while idle must be dropped and flagged.
    setup_model(0, 0, 0, 32'h0);
    mon_en = 1;
    @(posedge clk); #1 dst_valid = 1'b1; dst_data = $urandom;
    @(negedge clk);
    check("idle_dst_ready", dst_ready, 0);
    check("idle_no_wr", wr_en, 0);
    @(posedge clk); #1 dst_valid = 1'b0;
    @(negedge clk);
    check("idle_proto_err", proto_err, 1);
    run_batch(1, 1, 0, $urandom, 2, 0);

    // Reset while word 2 of 4 is in flight.
    setup_model(3, 0, 0, 32'h0);
    src_ready = 1'b1; mon_en = 1;
    @(posedge clk); #1 ss = 12'd3; ds = 12'd0; ns = '0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (src_xfers < 2 && n < 50) begin @(posedge clk); #1; n++; end
    if (src_xfers < 2) note_fail("reset_wait_xfers", src_xfers, 2);
    #2 mon_en = 0; rst_n = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_flags", {done, proto_err, rd_en, src_valid, src_last, dst_ready, wr_en}, 0);
    check("abort_buses", {rd_a, src_data, wr_a, wr_d}, 0);
    @(negedge clk); rst_n = 1;
    run_batch(3, 1, 0, $urandom, 0, 0);

    for (int t = 0; t < 8; t++)
      run_batch($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), $urandom,
                2, (t % 2) == 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
